// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an external up/down counter: start/pause/resume/abort commands, prescaled enable.
// Define COUNTER_SEQ_WRAPCNT_EN to build the saturating wrap_count; otherwise wrap_count is tied to 0.
module counter_seq_ctrl #(
  parameter int N       = 8,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [1:0]         cfg_mode,
  input  logic [N-1:0]       cfg_start,
  input  logic [N-1:0]       cfg_limit,
  input  logic [PRESC_W-1:0] cfg_presc,
  output logic               cnt_en,
  output logic               cnt_up,
  output logic               cnt_load,
  output logic               cnt_syn_clr,
  output logic [N-1:0]       cnt_d,
  output logic [N-1:0]       cnt_tope,
  input  logic               cnt_max_tick,
  input  logic               cnt_min_tick,
  output logic               busy,
  output logic               done_pulse,
  output logic               wrap_pulse,
  output logic [7:0]         wrap_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_DONE, S_CLEAR
  } state_e;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_PAUSE  = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_ABORT  = 2'b11;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PER  = 2'b10;

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [PRESC_W-1:0]   pcnt_q, pcnt_d, pcnt_inc;
  logic                 cnt_en_q, cnt_en_d;
  logic                 cnt_up_q, cnt_up_d;
  logic                 cnt_load_q, cnt_load_d;
  logic                 cnt_syn_clr_q, cnt_syn_clr_d;
  logic [N-1:0]         cnt_d_q, cnt_d_d;
  logic [N-1:0]         cnt_tope_q, cnt_tope_d;
  logic                 busy_q, busy_d;
  logic                 done_pulse_q, done_pulse_d;
  logic                 wrap_pulse_q, wrap_pulse_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 accept, term_evt, wrap_evt, immediate;

  assign accept   = cmd_valid && cmd_ready_q;
  assign pcnt_inc = (pcnt_q == presc_q) ? '0 : pcnt_q + PRESC_W'(1);
  assign term_evt = cnt_en_q && (((mode_q == MODE_UP) && cnt_max_tick) ||
                                 ((mode_q == MODE_DOWN) && cnt_min_tick));
  assign wrap_evt = cnt_en_q && (mode_q == MODE_PER) && cnt_min_tick;
  // cnt_d_q still carries the preload value while in LOAD, so it doubles as the latched start
  assign immediate = ((mode_q == MODE_DOWN) && (cnt_d_q == '0)) ||
                     ((mode_q == MODE_UP) && (cnt_d_q >= cnt_tope_q));

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    presc_d      = presc_q;
    pcnt_d       = pcnt_q;
    cnt_up_d     = cnt_up_q;
    cnt_tope_d   = cnt_tope_q;
    cnt_d_d      = '0;
    done_pulse_d = 1'b0;
    wrap_pulse_d = 1'b0;
    if (accept && (cmd_op == OP_START)) begin
      state_d    = S_LOAD;
      mode_d     = (cfg_mode == 2'b11) ? MODE_UP : cfg_mode;
      presc_d    = cfg_presc;
      pcnt_d     = '0;
      cnt_up_d   = (cfg_mode != MODE_DOWN);
      cnt_tope_d = cfg_limit;
      cnt_d_d    = cfg_start;
    end else if (accept && (cmd_op == OP_ABORT)) begin
      state_d = S_CLEAR;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (immediate) begin
            state_d      = S_DONE;
            done_pulse_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          // a terminal count beats a PAUSE arriving in the same cycle
          if (term_evt) begin
            state_d      = S_DONE;
            done_pulse_d = 1'b1;
            pcnt_d       = '0;
          end else begin
            wrap_pulse_d = wrap_evt;
            if (accept && (cmd_op == OP_PAUSE)) state_d = S_PAUSE;
            else                                pcnt_d  = pcnt_inc;
          end
        end
        S_PAUSE: begin
          if (accept && (cmd_op == OP_RESUME)) begin
            state_d = S_RUN;
            pcnt_d  = pcnt_inc;
          end
        end
        S_CLEAR: state_d = S_IDLE;
        default: ;
      endcase
    end
    cnt_en_d      = (state_d == S_RUN) && (pcnt_d == presc_d);
    cnt_load_d    = (state_d == S_LOAD);
    cnt_syn_clr_d = (state_d == S_CLEAR);
    busy_d        = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_PAUSE);
    cmd_ready_d   = (state_d != S_LOAD) && (state_d != S_CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mode_q        <= MODE_UP;
      presc_q       <= '0;
      pcnt_q        <= '0;
      cnt_en_q      <= 1'b0;
      cnt_up_q      <= 1'b0;
      cnt_load_q    <= 1'b0;
      cnt_syn_clr_q <= 1'b0;
      cnt_d_q       <= '0;
      cnt_tope_q    <= '0;
      busy_q        <= 1'b0;
      done_pulse_q  <= 1'b0;
      wrap_pulse_q  <= 1'b0;
      cmd_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      presc_q       <= presc_d;
      pcnt_q        <= pcnt_d;
      cnt_en_q      <= cnt_en_d;
      cnt_up_q      <= cnt_up_d;
      cnt_load_q    <= cnt_load_d;
      cnt_syn_clr_q <= cnt_syn_clr_d;
      cnt_d_q       <= cnt_d_d;
      cnt_tope_q    <= cnt_tope_d;
      busy_q        <= busy_d;
      done_pulse_q  <= done_pulse_d;
      wrap_pulse_q  <= wrap_pulse_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign cnt_en      = cnt_en_q;
  assign cnt_up      = cnt_up_q;
  assign cnt_load    = cnt_load_q;
  assign cnt_syn_clr = cnt_syn_clr_q;
  assign cnt_d       = cnt_d_q;
  assign cnt_tope    = cnt_tope_q;
  assign busy        = busy_q;
  assign done_pulse  = done_pulse_q;
  assign wrap_pulse  = wrap_pulse_q;

`ifdef COUNTER_SEQ_WRAPCNT_EN
  logic [7:0] wrap_count_q, wrap_count_d;

  // updates in step with wrap_pulse so the count and the pulse are visible together
  always_comb begin
    wrap_count_d = wrap_count_q;
    if (accept && ((cmd_op == OP_START) || (cmd_op == OP_ABORT))) wrap_count_d = '0;
    else if (wrap_pulse_d && (wrap_count_q != 8'hFF))             wrap_count_d = wrap_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap_count_q <= '0;
    else       wrap_count_q <= wrap_count_d;
  end

  assign wrap_count = wrap_count_q;
`else
  assign wrap_count = 8'd0;
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: drives commands against a stand-in counter and
// compares the DUT's pins with timings derived arithmetically from the mode/start/limit/presc rules.
module tb_counter_seq_ctrl;

  localparam int N       = 8;
  localparam int PRESC_W = 16;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_PAUSE  = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_ABORT  = 2'b11;

`ifdef COUNTER_SEQ_WRAPCNT_EN
  localparam bit WRAPCNT = 1'b1;
`else
  localparam bit WRAPCNT = 1'b0;
`endif

  logic               clk, reset;
  logic               cmd_valid, cmd_ready;
  logic [1:0]         cmd_op, cfg_mode;
  logic [N-1:0]       cfg_start, cfg_limit;
  logic [PRESC_W-1:0] cfg_presc;
  logic               cnt_en, cnt_up, cnt_load, cnt_syn_clr;
  logic [N-1:0]       cnt_d, cnt_tope;
  logic               cnt_max_tick, cnt_min_tick;
  logic               busy, done_pulse, wrap_pulse;
  logic [7:0]         wrap_count;
  logic [N-1:0]       cnt_q, cnt_next;
  logic [4:0]         obs;
  int                 checks, errors;

  counter_seq_ctrl #(.N(N), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cfg_mode(cfg_mode), .cfg_start(cfg_start), .cfg_limit(cfg_limit), .cfg_presc(cfg_presc),
    .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_load(cnt_load), .cnt_syn_clr(cnt_syn_clr),
    .cnt_d(cnt_d), .cnt_tope(cnt_tope),
    .cnt_max_tick(cnt_max_tick), .cnt_min_tick(cnt_min_tick),
    .busy(busy), .done_pulse(done_pulse), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count)
  );

  // stand-in for the attached universal counter, sharing the reset net
  always_comb begin
    cnt_next = cnt_q;
    if (cnt_syn_clr)   cnt_next = '0;
    else if (cnt_load) cnt_next = cnt_d;
    else if (cnt_en) begin
      if (cnt_up) cnt_next = (cnt_q == cnt_tope) ? '0 : cnt_q + 8'd1;
      else        cnt_next = (cnt_q == '0) ? cnt_tope : cnt_q - 8'd1;
    end
  end
  assign cnt_max_tick = (cnt_next == cnt_tope);
  assign cnt_min_tick = (cnt_next == '0);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_next;
  end

  assign obs = {cnt_load, cnt_en, done_pulse, wrap_pulse, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    cmd_op    = op;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_start(input int mode, input int start, input int limit, input int presc);
    cfg_mode  = 2'(mode);
    cfg_start = 8'(start);
    cfg_limit = 8'(limit);
    cfg_presc = 16'(presc);
    send_cmd(OP_START);
  endtask

  // expected {load, en, done, wrap, busy} idx cycles after the START was accepted
  function automatic logic [4:0] model_obs(input int idx, input int mode, input int start,
                                           input int limit, input int presc);
    int   p, m, n;
    logic imm, en, dn, wr, bz;
    p = presc + 1;
    m = (mode == 3) ? 0 : mode;
    if (idx == 0) return 5'b10001;
    imm = (m == 1 && start == 0) || (m == 0 && start >= limit);
    if (imm) begin
      dn = (idx == 1);
      return {2'b00, dn, 2'b00};
    end
    if (m == 2) begin
      en = (idx % p == 0);
      wr = (idx > 1) && ((idx - 1) % p == 0) && (((start + (idx - 1) / p) % (limit + 1)) == 0);
      return {1'b0, en, 1'b0, wr, 1'b1};
    end
    n  = (m == 0) ? limit - start : start;
    en = (idx % p == 0) && (idx / p <= n);
    dn = (idx == n * p + 1);
    bz = (idx <= n * p);
    return {1'b0, en, dn, 1'b0, bz};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if ({cmd_ready, cnt_en, cnt_up, cnt_load, cnt_syn_clr, busy, done_pulse, wrap_pulse} !== 8'b1000_0000 ||
        cnt_d !== 8'd0 || cnt_tope !== 8'd0 || wrap_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got ready/en/up/ld/clr/busy/done/wrap=%b d=%0d tope=%0d wc=%0d want 10000000 0 0 0",
               {cmd_ready, cnt_en, cnt_up, cnt_load, cnt_syn_clr, busy, done_pulse, wrap_pulse},
               cnt_d, cnt_tope, wrap_count);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_oneshot();
    int tm[5] = '{0, 1, 3, 1, 0};
    int ts[5] = '{3, 5, 2, 0, 9};
    int tl[5] = '{7, 0, 6, 9, 4};
    int tp[5] = '{0, 2, 1, 0, 0};
    int m, n, t, fin;
    logic imm, up_e;
    logic [4:0] exp;
    for (int r = 0; r < 5; r++) begin
      m    = (tm[r] == 3) ? 0 : tm[r];
      imm  = (m == 1 && ts[r] == 0) || (m == 0 && ts[r] >= tl[r]);
      n    = (m == 0) ? tl[r] - ts[r] : ts[r];
      t    = imm ? 3 : n * (tp[r] + 1) + 3;
      fin  = imm ? ts[r] : ((m == 0) ? tl[r] : 0);
      up_e = (m != 1);
      send_start(tm[r], ts[r], tl[r], tp[r]);
      checks++;
      if ({cnt_up, cnt_tope, cnt_d} !== {up_e, 8'(tl[r]), 8'(ts[r])}) begin
        errors++;
        $display("[TB] FAIL oneshot%0d_load up/tope/d got %b/%0d/%0d want %b/%0d/%0d",
                 r, cnt_up, cnt_tope, cnt_d, up_e, tl[r], ts[r]);
      end
      for (int idx = 0; idx <= t; idx++) begin
        exp = model_obs(idx, tm[r], ts[r], tl[r], tp[r]);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("[TB] FAIL oneshot%0d idx %0d ld/en/done/wrap/busy got %b want %b", r, idx, obs, exp);
        end
        tick();
      end
      checks++;
      if (cnt_q !== 8'(fin)) begin
        errors++;
        $display("[TB] FAIL oneshot%0d_final counter got %0d want %0d", r, cnt_q, fin);
      end
    end
  endtask

  task automatic test_periodic_wrap();
    logic [4:0] exp;
    logic [7:0] wc_exp;
    wc_exp = WRAPCNT ? 8'd3 : 8'd0;
    send_start(2, 0, 3, 0);
    for (int idx = 0; idx <= 14; idx++) begin
      exp = model_obs(idx, 2, 0, 3, 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL periodic idx %0d ld/en/done/wrap/busy got %b want %b", idx, obs, exp);
      end
      if (idx == 13) begin
        checks++;
        if (wrap_count !== wc_exp) begin
          errors++;
          $display("[TB] FAIL periodic_wrap_count got %0d want %0d", wrap_count, wc_exp);
        end
      end
      tick();
    end
    send_cmd(OP_ABORT);
    checks++;
    if ({cnt_syn_clr, busy, cmd_ready, wrap_pulse, done_pulse} !== 5'b10000 || wrap_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL periodic_abort clr/busy/ready/wrap/done got %b wc %0d want 10000 wc 0",
               {cnt_syn_clr, busy, cmd_ready, wrap_pulse, done_pulse}, wrap_count);
    end
    tick();
    checks++;
    if ({cnt_syn_clr, cmd_ready, busy} !== 3'b010 || cnt_q !== 8'd0) begin
      errors++;
      $display("[TB] FAIL periodic_idle clr/ready/busy got %b q %0d want 010 q 0",
               {cnt_syn_clr, cmd_ready, busy}, cnt_q);
    end
  endtask

  task automatic test_pause_resume();
    logic [4:0] exp;
    logic [2:0] en_hist;
    send_start(0, 0, 20, 4);
    for (int idx = 0; idx <= 7; idx++) begin
      exp = model_obs(idx, 0, 0, 20, 4);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL pause_pre idx %0d ld/en/done/wrap/busy got %b want %b", idx, obs, exp);
      end
      if (idx < 7) tick();
    end
    send_cmd(OP_PAUSE);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({cnt_en, busy, cmd_ready, cnt_q} !== {3'b011, 8'd1}) begin
        errors++;
        $display("[TB] FAIL pause_hold cyc %0d en/busy/ready got %b q %0d want 011 q 1",
                 c, {cnt_en, busy, cmd_ready}, cnt_q);
      end
      tick();
    end
    send_cmd(OP_RESUME);
    for (int c = 0; c < 3; c++) begin
      en_hist[c] = cnt_en;
      if (c < 2) tick();
    end
    checks++;
    if (en_hist !== 3'b100 || cnt_q !== 8'd1) begin
      errors++;
      $display("[TB] FAIL resume_timing en cyc3..1 got %b q %0d want 100 q 1", en_hist, cnt_q);
    end
    tick();
    send_cmd(OP_ABORT);
    tick();
  endtask

  task automatic test_terminal_collisions();
    logic [4:0] exp;
    logic       done_seen;
    for (int pass = 0; pass < 2; pass++) begin
      send_start(0, 2, 5, 1);
      for (int idx = 0; idx <= 6; idx++) begin
        exp = model_obs(idx, 0, 2, 5, 1);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("[TB] FAIL collide%0d idx %0d ld/en/done/wrap/busy got %b want %b", pass, idx, obs, exp);
        end
        if (idx < 6) tick();
      end
      if (pass == 0) begin
        send_cmd(OP_ABORT);
        checks++;
        if ({cnt_syn_clr, done_pulse, busy, cmd_ready} !== 4'b1000) begin
          errors++;
          $display("[TB] FAIL abort_terminal clr/done/busy/ready got %b want 1000",
                   {cnt_syn_clr, done_pulse, busy, cmd_ready});
        end
        done_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
          tick();
          done_seen |= done_pulse;
        end
        checks++;
        if ({done_seen, cnt_syn_clr, cmd_ready} !== 3'b001 || cnt_q !== 8'd0) begin
          errors++;
          $display("[TB] FAIL abort_after done_seen/clr/ready got %b q %0d want 001 q 0",
                   {done_seen, cnt_syn_clr, cmd_ready}, cnt_q);
        end
      end else begin
        send_cmd(OP_PAUSE);
        checks++;
        if ({done_pulse, busy, cnt_en, cmd_ready} !== 4'b1001 || cnt_q !== 8'd5) begin
          errors++;
          $display("[TB] FAIL pause_terminal done/busy/en/ready got %b q %0d want 1001 q 5",
                   {done_pulse, busy, cnt_en, cmd_ready}, cnt_q);
        end
        tick();
        send_cmd(OP_RESUME);
        tick();
        checks++;
        if ({done_pulse, busy, cnt_en} !== 3'b000 || cnt_q !== 8'd5) begin
          errors++;
          $display("[TB] FAIL resume_in_done done/busy/en got %b q %0d want 000 q 5",
                   {done_pulse, busy, cnt_en}, cnt_q);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    send_start(0, 1, 200, 0);
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, cnt_en, cnt_load, busy, cnt_up} !== 5'b10000 || cnt_tope !== 8'd0 || cnt_q !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_midrun ready/en/ld/busy/up got %b tope %0d q %0d want 10000 0 0",
               {cmd_ready, cnt_en, cnt_load, busy, cnt_up}, cnt_tope, cnt_q);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int mode, start, limit, presc, m, n, t, fin, wraps;
    logic imm;
    logic [4:0] exp;
    logic [7:0] wc_exp;
    for (int it = 0; it < 16; it++) begin
      mode  = int'($urandom_range(0, 3));
      limit = int'($urandom_range(1, 12));
      presc = int'($urandom_range(0, 3));
      start = (mode == 2) ? int'($urandom_range(0, limit)) : int'($urandom_range(0, 14));
      m     = (mode == 3) ? 0 : mode;
      imm   = (m == 1 && start == 0) || (m == 0 && start >= limit);
      n     = (m == 0) ? limit - start : start;
      t     = (m == 2) ? 30 : (imm ? 3 : n * (presc + 1) + 3);
      fin   = imm ? start : ((m == 0) ? limit : 0);
      wraps = 0;
      send_start(mode, start, limit, presc);
      for (int idx = 0; idx <= t; idx++) begin
        exp = model_obs(idx, mode, start, limit, presc);
        if (exp[1]) wraps++;
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("[TB] FAIL random%0d m%0d s%0d l%0d p%0d idx %0d got %b want %b",
                   it, mode, start, limit, presc, idx, obs, exp);
        end
        if (m == 2 && idx == t) begin
          wc_exp = WRAPCNT ? 8'(wraps) : 8'd0;
          checks++;
          if (wrap_count !== wc_exp) begin
            errors++;
            $display("[TB] FAIL random%0d wrap_count got %0d want %0d", it, wrap_count, wc_exp);
          end
        end
        tick();
      end
      if (m == 2) begin
        send_cmd(OP_ABORT);
        tick();
      end else begin
        checks++;
        if (cnt_q !== 8'(fin)) begin
          errors++;
          $display("[TB] FAIL random%0d final counter got %0d want %0d", it, cnt_q, fin);
        end
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_START;
    cfg_mode  = 2'b00;
    cfg_start = '0;
    cfg_limit = '0;
    cfg_presc = '0;
    test_reset();
    test_oneshot();
    test_periodic_wrap();
    test_pause_resume();
    test_terminal_collisions();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
